i2c_slave: RTL and testbench
============================

// Module: i2c_slave
// PURPOSE
//  I2C target (responder) for the same bus the i2c_master block drives.
//  Oversamples SCL/SDA on i_clk, detects START/STOP, and matches a 7-bit address.
//  Receives write bytes to the user side, serves read bytes from the user side.
//  Drives SDA open-drain (0 or Z only); never drives SCL (no clock stretching).
// PARAMETERS
//  SLAVE_ADDR  7'h50  7-bit bus address this target answers to
//  DATA_SIZE   8      byte width; fixed by the protocol, do not override
//  SYNC_STAGES 2      synchronizer flops on i_scl and io_sda (>=2)
// PORTS
//  i_clk       in   1          system clock, >= 8x SCL frequency
//  i_rst_n     in   1          asynchronous, active-low reset
//  i_scl       in   1          bus SCL (input only)
//  io_sda      inout 1         bus SDA; driven 1'b0 or 1'bz only
//  i_tx_data   in   DATA_SIZE  byte to return on a read; sampled per o_tx_req
//  o_tx_req    out  1          1-cycle pulse: present the next read byte on i_tx_data
//  o_rx_data   out  DATA_SIZE  last byte written by the master
//  o_rx_valid  out  1          1-cycle pulse: o_rx_data updated
//  o_rw        out  1          R/W bit of the current transfer (1 = read)
//  o_busy      out  1          1 from a matched address ACK until STOP/mismatch
// BEHAVIOUR
//  Reset values: SDA released (Z), o_tx_req=0, o_rx_valid=0, o_rx_data=0, o_rw=0,
//   o_busy=0, state=IDLE, bit count=0. Reset mid-transfer releases SDA asynchronously.
//  Front end: SYNC_STAGES flops per line; edges are taken from the last two sync flops.
//   START = SDA fall while SCL high.
//   STOP  = SDA rise while SCL high.
//   Data is sampled on an SCL rise; SDA is changed only on an SCL fall.
//   Edge-to-action latency is SYNC_STAGES+1 i_clk cycles.
//  States: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
//   IDLE: START -> ADDR, bit count=0.
//   ADDR: shift 8 bits MSB first (7 address bits + R/W).
//    On the 8th rise: address match -> ADDR_ACK and latch o_rw; otherwise -> WAIT_STOP.
//   ADDR_ACK: pull SDA low from the SCL fall after bit 8 through the next SCL fall.
//    o_busy=1. Then -> RX_BYTE (write) or TX_BYTE (read).
//    For a read, o_tx_req pulses on the ACK-slot SCL rise. i_tx_data is captured
//    on the ACK-slot SCL fall, and bit 7 is driven on that same fall.
//   RX_BYTE: shift 8 bits; on the 8th rise -> RX_ACK.
//    o_rx_data updates and o_rx_valid pulses one cycle after the 8th rise.
//    ACK is always given; there is no receive backpressure.
//   RX_ACK: pull SDA low for one SCL period; -> RX_BYTE.
//   TX_BYTE: on each SCL fall, drive Z for a 1 bit or 0 for a 0 bit, MSB first.
//    After 8 bits release SDA -> TX_ACK.
//   TX_ACK: sample master ACK on the SCL rise.
//    SDA=0 (ACK): pulse o_tx_req on that rise, capture i_tx_data on the next fall,
//     -> TX_BYTE.
//    SDA=1 (NACK): -> WAIT_STOP.
//   WAIT_STOP: SDA released, input ignored; START -> ADDR, STOP -> IDLE.
//  Global rules: STOP in any state -> IDLE, SDA released, o_busy=0.
//   Repeated START in any state -> ADDR, count=0, SDA released, o_busy=0.
//   A START/STOP seen while SDA is driven by us is a bus error: same handling.
//  Bit counter is 3 bits and wraps 7->0 at each byte boundary.
//  No general call, no 10-bit addressing. A master NACK ends a read.
//  o_tx_req and o_rx_valid never assert in the same cycle.
// TESTING
//  1. Write 0x50 W, data 0xA5, 0x3C, STOP -> ACK on addr and both bytes.
//     o_rx_valid pulses twice with o_rx_data 0xA5 then 0x3C; o_busy 1 then 0 after STOP.
//  2. Address 0x51 W -> SDA stays Z (NACK seen by master); no o_rx_valid.
//     Next START with 0x50 is accepted.
//  3. Read 0x50 R, user supplies 0x96 then 0x0F, master ACKs then NACKs -> SDA shows
//     1001_0110 then 0000_1111. Two o_tx_req pulses; WAIT_STOP until STOP.
//  4. Write 0x50 W, byte 0x11, repeated START, 0x50 R -> o_rx_data=0x11, o_rw 0->1,
//     read proceeds with no STOP in between.
//  5. Assert i_rst_n=0 while driving a 0 data bit in TX_BYTE -> SDA Z in the same
//     cycle, all outputs at reset values, IDLE.
//  6. STOP injected after 4 bits of RX_BYTE -> IDLE, no o_rx_valid, SDA released.

Source files
------------

// File: rtl/i2c_slave.sv
// I2C target (responder) with a fixed 7-bit address. SCL and SDA are oversampled on
// i_clk; START/STOP and SCL edges come from the synchronized copies. Written bytes are
// handed out on o_rx_data/o_rx_valid; read bytes are requested with o_tx_req and taken
// from i_tx_data. SDA is driven open-drain (0 or Z); SCL is never driven.
//
// Ports:
//   i_clk       system clock, at least 8x the SCL frequency
//   i_rst_n     asynchronous active-low reset
//   i_scl       bus SCL (input only)
//   io_sda      bus SDA, driven 1'b0 or 1'bz only
//   i_tx_data   byte returned on a read; captured on the SCL fall after o_tx_req
//   o_tx_req    1-cycle pulse: present the next read byte on i_tx_data
//   o_rx_data   last byte written by the master
//   o_rx_valid  1-cycle pulse: o_rx_data updated
//   o_rw        R/W bit of the current transfer (1 = read)
//   o_busy      1 from a matched address until STOP or a new START
module i2c_slave #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned DATA_SIZE   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_scl,
  inout  wire                  io_sda,
  input  logic [DATA_SIZE-1:0] i_tx_data,
  output logic                 o_tx_req,
  output logic [DATA_SIZE-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_rw,
  output logic                 o_busy
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StRxByte, StRxAck, StTxByte, StTxAck, StWaitStop
  } state_e;

  // Synchronizers; reset to the idle-bus level so reset release is not seen as an edge.
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_sync_q <= {SYNC_STAGES{1'b1}};
      sda_sync_q <= {SYNC_STAGES{1'b1}};
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i_scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], io_sda};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  logic scl_cur, sda_cur, scl_rise, scl_fall, start_det, stop_det;
  assign scl_cur   = scl_sync_q[SYNC_STAGES-1];
  assign sda_cur   = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_cur & ~scl_prev_q;
  assign scl_fall  = ~scl_cur & scl_prev_q;
  // SCL must be high on both samples so an SDA change racing an SCL fall is not a START/STOP.
  assign start_det = scl_cur & scl_prev_q & sda_prev_q & ~sda_cur;
  assign stop_det  = scl_cur & scl_prev_q & ~sda_prev_q & sda_cur;

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] sh_q, sh_d;
  logic                 oe_q, oe_d;
  // Second-half marker for two-step states: ACK being driven (ADDR_ACK/RX_ACK) or
  // master ACK seen and next byte pending (TX_ACK).
  logic                 phase_q, phase_d;
  logic                 rw_q, rw_d;
  logic                 busy_q, busy_d;
  logic [DATA_SIZE-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 tx_req_q, tx_req_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    oe_d       = oe_q;
    phase_d    = phase_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    if (stop_det) begin
      state_d = StIdle;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
      phase_d = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = StAddr;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
      phase_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr: begin
          if (scl_rise) begin
            sh_d  = {sh_q[DATA_SIZE-2:0], sda_cur};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (sh_d[DATA_SIZE-1:1] == SLAVE_ADDR) begin
                state_d = StAddrAck;
                rw_d    = sda_cur;
                busy_d  = 1'b1;
                phase_d = 1'b0;
              end else begin
                state_d = StWaitStop;
              end
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            if (!phase_q) begin
              oe_d    = 1'b1;
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              cnt_d   = 3'd0;
              if (rw_q) begin
                sh_d    = i_tx_data;
                oe_d    = ~i_tx_data[DATA_SIZE-1];
                state_d = StTxByte;
              end else begin
                oe_d    = 1'b0;
                state_d = StRxByte;
              end
            end
          end else if (scl_rise && phase_q && rw_q) begin
            tx_req_d = 1'b1;
          end
        end
        StRxByte: begin
          if (scl_rise) begin
            sh_d  = {sh_q[DATA_SIZE-2:0], sda_cur};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_d    = StRxAck;
              phase_d    = 1'b0;
              rx_data_d  = sh_d;
              rx_valid_d = 1'b1;
            end
          end
        end
        StRxAck: begin
          if (scl_fall) begin
            if (!phase_q) begin
              oe_d    = 1'b1;
              phase_d = 1'b1;
            end else begin
              oe_d    = 1'b0;
              phase_d = 1'b0;
              state_d = StRxByte;
            end
          end
        end
        StTxByte: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_d = StTxAck;
              phase_d = 1'b0;
            end
          end else if (scl_fall) begin
            // After k sampled bits the next bit to drive is bit 7-k.
            oe_d = ~sh_q[~cnt_q];
          end
        end
        StTxAck: begin
          if (scl_fall) begin
            if (!phase_q) begin
              oe_d = 1'b0;
            end else begin
              sh_d    = i_tx_data;
              oe_d    = ~i_tx_data[DATA_SIZE-1];
              cnt_d   = 3'd0;
              phase_d = 1'b0;
              state_d = StTxByte;
            end
          end else if (scl_rise && !phase_q) begin
            if (!sda_cur) begin
              tx_req_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              state_d = StWaitStop;
            end
          end
        end
        StWaitStop: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      sh_q       <= '0;
      oe_q       <= 1'b0;
      phase_q    <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      oe_q       <= oe_d;
      phase_q    <= phase_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
    end
  end

  assign io_sda     = oe_q ? 1'b0 : 1'bz;
  assign o_tx_req   = tx_req_q;
  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_rw       = rw_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: a bit-banged I2C master drives the bus, and a
// transaction-level model (address match, byte lists, ACK expectations) supplies the
// expected results for randomized writes, reads, repeated STARTs and aborts.
module tb_i2c_slave;

  localparam int Q = 10;  // clocks per SCL quarter period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        sda_bus;
  logic       tx_req, rx_valid, rw, busy;
  logic [7:0] rx_data;

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_scl     (scl),
    .io_sda    (sda_bus),
    .i_tx_data (tx_data),
    .o_tx_req  (tx_req),
    .o_rx_data (rx_data),
    .o_rx_valid(rx_valid),
    .o_rw      (rw),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Passive monitor of user-side pulses.
  logic [7:0] rx_log[$];
  int tx_req_cnt = 0;
  int collide = 0;
  always @(posedge clk) begin
    if (rx_valid) rx_log.push_back(rx_data);
    if (tx_req) tx_req_cnt <= tx_req_cnt + 1;
    if (tx_req && rx_valid) collide <= collide + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // START from idle, or repeated START when SCL is low.
  task automatic bus_start();
    if (!scl) begin
      tick(2); m_sda_low = 1'b0; tick(Q); scl = 1'b1; tick(Q);
    end
    m_sda_low = 1'b1; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    tick(2); m_sda_low = 1'b1; tick(Q); scl = 1'b1; tick(Q); m_sda_low = 1'b0; tick(Q);
  endtask

  // One SCL period: master puts b on SDA (1 = release), samples SDA mid-high, notes any
  // o_tx_req during the high phase and, if serve, presents nxt on i_tx_data.
  task automatic bit_cycle(input logic b, input logic serve, input logic [7:0] nxt,
                           output logic rd, output logic req);
    tick(2); m_sda_low = !b; tick(Q); scl = 1'b1; req = 1'b0;
    for (int k = 0; k < Q; k++) begin
      tick(1);
      if (tx_req) req = 1'b1;
    end
    if (serve) tx_data = nxt;
    rd = sda_bus; tick(Q); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic serve, input logic [7:0] nxt,
                           output logic ack, output logic req);
    logic rd, r;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], 1'b0, 8'h00, rd, r);
    bit_cycle(1'b1, serve, nxt, ack, req);
  endtask

  task automatic recv_byte(input logic master_ack, input logic serve, input logic [7:0] nxt,
                           output logic [7:0] b, output logic req);
    logic rd, r, a;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, 1'b0, 8'h00, rd, r);
      b[i] = rd;
    end
    bit_cycle(!master_ack, serve, nxt, a, req);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(3); rst_n = 1'b1; tick(5);
    checks++;
    if ({tx_req, rx_valid, rx_data, rw, busy, sda_bus} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_values: got %b expected %b",
               {tx_req, rx_valid, rx_data, rw, busy, sda_bus}, 13'b0_0_00000000_0_0_1);
    else passed++;
  endtask

  task automatic test_write(input int n, input logic fixed);
    logic [7:0] exp[$];
    logic ack, req;
    logic [7:0] b;
    rx_log.delete();
    bus_start();
    send_byte({7'h50, 1'b0}, 1'b0, 8'h00, ack, req);
    checks++;
    if (ack !== 1'b0) $display("FAIL wr_addr_ack: got %b expected 0", ack); else passed++;
    checks++;
    if (busy !== 1'b1) $display("FAIL wr_busy: got %b expected 1", busy); else passed++;
    for (int i = 0; i < n; i++) begin
      b = fixed ? ((i == 0) ? 8'hA5 : 8'h3C) : 8'($urandom);
      exp.push_back(b);
      send_byte(b, 1'b0, 8'h00, ack, req);
      checks++;
      if (ack !== 1'b0) $display("FAIL wr_data_ack: byte %0d got %b expected 0", i, ack);
      else passed++;
    end
    bus_stop(); tick(5);
    checks++;
    if (busy !== 1'b0) $display("FAIL wr_busy_after_stop: got %b expected 0", busy);
    else passed++;
    checks++;
    if (rx_log.size() != n) $display("FAIL wr_rx_count: got %0d expected %0d", rx_log.size(), n);
    else passed++;
    for (int i = 0; i < n && i < rx_log.size(); i++) begin
      checks++;
      if (rx_log[i] !== exp[i])
        $display("FAIL wr_rx_data: byte %0d got %h expected %h", i, rx_log[i], exp[i]);
      else passed++;
    end
    checks++;
    if (rw !== 1'b0) $display("FAIL wr_rw: got %b expected 0", rw); else passed++;
  endtask

  task automatic test_nack_addr();
    logic [6:0] a;
    logic ack, req;
    int req0;
    do a = 7'($urandom); while (a == 7'h50);
    rx_log.delete();
    req0 = tx_req_cnt;
    bus_start();
    send_byte({a, 1'($urandom)}, 1'b0, 8'h00, ack, req);
    checks++;
    if (ack !== 1'b1) $display("FAIL nack_addr: addr %h got ack %b expected 1", a, ack);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL nack_busy: got %b expected 0", busy); else passed++;
    send_byte(8'($urandom), 1'b0, 8'h00, ack, req);
    checks++;
    if (ack !== 1'b1) $display("FAIL nack_data_ignored: got ack %b expected 1", ack);
    else passed++;
    bus_stop(); tick(5);
    checks++;
    if (rx_log.size() != 0 || tx_req_cnt != req0)
      $display("FAIL nack_no_pulses: got rx %0d req %0d expected rx 0 req 0",
               rx_log.size(), tx_req_cnt - req0);
    else passed++;
  endtask

  task automatic test_read(input int n, input logic fixed);
    logic [7:0] exp[$];
    logic [7:0] got;
    logic ack, req;
    int req0;
    for (int i = 0; i < n; i++)
      exp.push_back(fixed ? ((i == 0) ? 8'h96 : 8'h0F) : 8'($urandom));
    exp.push_back(8'h00);
    req0 = tx_req_cnt;
    bus_start();
    send_byte({7'h50, 1'b1}, 1'b1, exp[0], ack, req);
    checks++;
    if (ack !== 1'b0 || req !== 1'b1)
      $display("FAIL rd_addr_ack_req: got ack %b req %b expected ack 0 req 1", ack, req);
    else passed++;
    checks++;
    if (rw !== 1'b1) $display("FAIL rd_rw: got %b expected 1", rw); else passed++;
    for (int i = 0; i < n; i++) begin
      recv_byte(i < n - 1, i < n - 1, exp[i+1], got, req);
      checks++;
      if (got !== exp[i]) $display("FAIL rd_data: byte %0d got %h expected %h", i, got, exp[i]);
      else passed++;
      checks++;
      if (req !== (i < n - 1))
        $display("FAIL rd_ack_req: byte %0d got %b expected %b", i, req, i < n - 1);
      else passed++;
    end
    bus_stop(); tick(5);
    checks++;
    if (tx_req_cnt - req0 != n || busy !== 1'b0)
      $display("FAIL rd_end: got req %0d busy %b expected req %0d busy 0",
               tx_req_cnt - req0, busy, n);
    else passed++;
  endtask

  task automatic test_repeated_start();
    logic [7:0] b, d, got;
    logic ack, req;
    b = 8'($urandom); d = 8'($urandom);
    rx_log.delete();
    bus_start();
    send_byte({7'h50, 1'b0}, 1'b0, 8'h00, ack, req);
    send_byte(b, 1'b0, 8'h00, ack, req);
    checks++;
    if (ack !== 1'b0 || rw !== 1'b0)
      $display("FAIL rs_write: got ack %b rw %b expected 0 0", ack, rw);
    else passed++;
    bus_start();
    send_byte({7'h50, 1'b1}, 1'b1, d, ack, req);
    checks++;
    if (ack !== 1'b0 || rw !== 1'b1 || req !== 1'b1)
      $display("FAIL rs_read_addr: got ack %b rw %b req %b expected 0 1 1", ack, rw, req);
    else passed++;
    checks++;
    if (rx_log.size() != 1 || rx_data !== b)
      $display("FAIL rs_rx_data: got %h (n=%0d) expected %h", rx_data, rx_log.size(), b);
    else passed++;
    recv_byte(1'b0, 1'b0, 8'h00, got, req);
    checks++;
    if (got !== d) $display("FAIL rs_read_data: got %h expected %h", got, d); else passed++;
    bus_stop(); tick(5);
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] d;
    logic ack, req;
    d = 8'($urandom) & 8'h7F;
    bus_start();
    send_byte({7'h50, 1'b1}, 1'b1, d, ack, req);
    tick(5);
    checks++;
    if (sda_bus !== 1'b0) $display("FAIL rst_tx_bit7_driven: got %b expected 0", sda_bus);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sda_bus, tx_req, rx_valid, rx_data, rw, busy} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0})
      $display("FAIL rst_async: got %b expected %b",
               {sda_bus, tx_req, rx_valid, rx_data, rw, busy}, 13'b1_0_0_00000000_0_0);
    else passed++;
    tick(3); rst_n = 1'b1; tick(3); scl = 1'b1; tick(Q);
  endtask

  task automatic test_stop_mid_rx();
    logic ack, req, rd, r;
    rx_log.delete();
    bus_start();
    send_byte({7'h50, 1'b0}, 1'b0, 8'h00, ack, req);
    for (int i = 0; i < 4; i++) bit_cycle(1'($urandom), 1'b0, 8'h00, rd, r);
    bus_stop(); tick(5);
    checks++;
    if (rx_log.size() != 0 || busy !== 1'b0 || sda_bus !== 1'b1)
      $display("FAIL stop_mid_rx: got rx %0d busy %b sda %b expected 0 0 1",
               rx_log.size(), busy, sda_bus);
    else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(1) == 1) test_write($urandom_range(1, 4), 1'b0);
      else test_read($urandom_range(1, 4), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_write(2, 1'b1);
    test_nack_addr();
    test_write(1, 1'b0);
    test_read(2, 1'b1);
    test_read($urandom_range(1, 4), 1'b0);
    test_repeated_start();
    test_reset_mid_tx();
    test_write(1, 1'b0);
    test_stop_mid_rx();
    test_write($urandom_range(1, 3), 1'b0);
    test_back_to_back();
    checks++;
    if (collide != 0) $display("FAIL req_valid_overlap: got %0d expected 0", collide);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
